mole_round_engine: RTL

//  Parametrised game engine for the whack-a-box game. It times a round, draws target boxes from the LFSR,
//  and opens a per-target hit window that shrinks with difficulty. It scores hits, wrong hits and misses,
//  and pulses the audio enable. Sits between lfsr/read_sensor front-ends and HEX/VGA/audio back-ends.

---
 rtl/mole_pkg.sv | 27 ++
 rtl/mole_tick_gen.sv | 40 ++++
 rtl/mole_round_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-box round engine.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_HIT,
        OVER
    } state_e;

    localparam int unsigned LEVEL_MIN = 1;
    localparam int unsigned LEVEL_MAX = 3;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/mole_tick_gen.sv
// Seconds prescaler: one-cycle sec_strobe_o every TICKS_PER_SEC enabled cycles.
module mole_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic sec_strobe_o
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d        = cnt_q;
        sec_strobe_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d        = '0;
                sec_strobe_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mole_round_engine.sv
// Whack-a-box round engine: round timer, target draw, hit window, scoring, sound.
// Optional streak bonus built when MOLE_STREAK_BONUS_EN is defined.
module mole_round_engine
    import mole_pkg::*;
#(
    parameter int unsigned NUM_BOXES     = 8,
    parameter int unsigned BOX_W         = 3,
    parameter int unsigned SCORE_W       = 11,
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned GAME_SECS     = 60,
    parameter int unsigned WINDOW_TICKS  = 75_000_000,
    parameter int unsigned SOUND_TICKS   = 5_000_000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start_game,
    input  logic [BOX_W-1:0]   rand_box,
    input  logic               hit_valid,
    input  logic [BOX_W-1:0]   hit_box,
    output logic [BOX_W-1:0]   target_box,
    output logic               target_valid,
    output logic [SCORE_W-1:0] score,
    output logic [5:0]         time_left,
    output logic [1:0]         difficulty_level,
    output logic               play_sound,
    output logic               game_over,
    output logic [2:0]         streak
);

    localparam int unsigned WIN_W = $clog2(WINDOW_TICKS + 1);
    localparam int unsigned SND_W = (SOUND_TICKS > 0) ? $clog2(SOUND_TICKS + 1) : 1;
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    state_e               state_q, state_d;
    logic [BOX_W-1:0]     target_q, target_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [5:0]           time_q, time_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [SND_W-1:0]     snd_q, snd_d;

    logic       active, start_go, draw_ok, hit_ok, hit_bad, expire, time_up;
    logic       sec_strobe, bonus;
    logic [1:0] level;
    logic [5:0] elapsed;
    logic [31:0] gain;

    mole_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk_i       (CLOCK_50),
        .rst_i       (reset),
        .en_i        (active),
        .clr_i       (start_go),
        .sec_strobe_o(sec_strobe)
    );

    assign active   = (state_q == ARM) || (state_q == WAIT_HIT);
    assign start_go = start_game && ((state_q == IDLE) || (state_q == OVER));
    assign draw_ok  = (32'(rand_box) < NUM_BOXES) && (rand_box != target_q);
    assign hit_ok   = (state_q == WAIT_HIT) && hit_valid && (hit_box == target_q);
    assign hit_bad  = (state_q == WAIT_HIT) && hit_valid && (hit_box != target_q);
    // A hit in the last window cycle wins over the expiry.
    assign expire   = (state_q == WAIT_HIT) && !hit_valid && (win_q <= WIN_W'(1));
    assign elapsed  = 6'(GAME_SECS) - time_q;

    always_comb begin
        if (elapsed < 6'(GAME_SECS / 3)) begin
            level = 2'(LEVEL_MIN);
        end else if (elapsed < 6'(2 * GAME_SECS / 3)) begin
            level = 2'(LEVEL_MIN + 1);
        end else begin
            level = 2'(LEVEL_MAX);
        end
    end

    always_comb begin
        time_d = time_q;
        if (start_go) begin
            time_d = 6'(GAME_SECS);
        end else if (active && sec_strobe && (time_q != '0)) begin
            time_d = time_q - 6'd1;
        end
    end

    assign time_up = active && (time_d == '0);

`ifdef MOLE_STREAK_BONUS_EN
    logic [2:0] streak_q, streak_d;
    logic [1:0] quad_q, quad_d;

    // quad_q tracks position within groups of four, since streak_q saturates at 7.
    always_comb begin
        streak_d = streak_q;
        quad_d   = quad_q;
        if (start_go) begin
            streak_d = '0;
            quad_d   = '0;
        end else if (hit_ok) begin
            streak_d = (streak_q == 3'd7) ? streak_q : streak_q + 3'd1;
            quad_d   = quad_q + 2'd1;
        end else if (hit_bad || expire) begin
            streak_d = '0;
            quad_d   = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            streak_q <= '0;
            quad_q   <= '0;
        end else begin
            streak_q <= streak_d;
            quad_q   <= quad_d;
        end
    end

    assign bonus  = hit_ok && (quad_q == 2'd3);
    assign streak = streak_q;
`else
    assign bonus  = 1'b0;
    assign streak = '0;
`endif

    assign gain = bonus ? (32'(level) << 1) : 32'(level);

    always_comb begin
        score_d  = score_q;
        target_d = target_q;
        win_d    = win_q;
        snd_d    = snd_q;
        if (start_go) begin
            score_d = '0;
        end else if (hit_ok) begin
            score_d = SCORE_W'(sat_add(32'(score_q), gain, SCORE_MAX));
        end else if (hit_bad || expire) begin
            score_d = SCORE_W'(sat_sub(32'(score_q), 32'd1));
        end
        if ((state_q == ARM) && draw_ok) begin
            target_d = rand_box;
            win_d    = WIN_W'(WINDOW_TICKS >> (32'(level) - LEVEL_MIN));
        end else if ((state_q == WAIT_HIT) && (win_q != '0)) begin
            win_d = win_q - 1'b1;
        end
        if (hit_ok) begin
            snd_d = SND_W'(SOUND_TICKS);
        end else if (snd_q != '0) begin
            snd_d = snd_q - 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            score_q  <= '0;
            target_q <= '0;
            time_q   <= 6'(GAME_SECS);
            win_q    <= '0;
            snd_q    <= '0;
        end else begin
            score_q  <= score_d;
            target_q <= target_d;
            time_q   <= time_d;
            win_q    <= win_d;
            snd_q    <= snd_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, OVER: if (start_game) state_d = ARM;
            ARM: begin
                if (time_up) begin
                    state_d = OVER;
                end else if (draw_ok) begin
                    state_d = WAIT_HIT;
                end
            end
            WAIT_HIT: begin
                if (time_up) begin
                    state_d = OVER;
                end else if (hit_ok || expire) begin
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        target_valid     = (state_q == WAIT_HIT);
        game_over        = (state_q == OVER);
        target_box       = target_q;
        score            = score_q;
        time_left        = time_q;
        difficulty_level = level;
        play_sound       = (snd_q != '0);
    end

endmodule
